// File: rtl/data_memory_pipe_pkg.sv
// Shared types and helpers for the parametrised MEM-stage data memory.
// Word merging works on a fixed maximum width so one function serves every DATA_WIDTH.
package memPkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 1024;
  localparam int MAX_BYTES = MAX_WIDTH / 8;

  function automatic int calc_off(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int calc_idx(input int depth);
    return $clog2(depth);
  endfunction

  // Bytes with byte_en set come from new_word, the rest keep old_word.
  function automatic logic [MAX_WIDTH-1:0] merge_bytes(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_BYTES-1:0] byte_en
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_memory_pipe_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
// Kept free of reset and control logic so a vendor macro can replace it.
module memArrayBe
  import memPkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int IDX       = calc_idx(DEPTH),
  localparam int BYTES     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [IDX-1:0]        addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BYTES-1:0]      be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [MAX_WIDTH-1:0] old_ext;
  logic [MAX_WIDTH-1:0] new_ext;
  logic [MAX_WIDTH-1:0] merged_ext;
  logic [MAX_BYTES-1:0] be_ext;

  always_comb begin
    old_ext                   = '0;
    new_ext                   = '0;
    be_ext                    = '0;
    old_ext[DATA_WIDTH-1:0]   = mem[addr];
    new_ext[DATA_WIDTH-1:0]   = wdata;
    be_ext[BYTES-1:0]         = be;
    merged_ext                = merge_bytes(old_ext, new_ext, be_ext);
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= merged_ext[DATA_WIDTH-1:0];
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_pipe.sv
// MEM-stage data memory: request handshake, alignment/range checking, post-reset
// clear sequencer and a one-cycle registered response around memArrayBe.
module data_memory_pipe
  import memPkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BYTES         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [DATA_WIDTH-1:0] reqWData,
  input  logic [BYTES-1:0]      reqByteEn,
  output logic                  rspValid,
  output logic [DATA_WIDTH-1:0] rspRData,
  output logic                  rspError,
  output logic                  clearBusy,
  output logic                  dbgState
);

  localparam int OFF = calc_off(DATA_WIDTH);
  localparam int IDX = calc_idx(DEPTH);

  state_t               state_q;
  state_t               state_d;
  logic [IDX-1:0]       clr_idx_q;
  logic [IDX-1:0]       clr_idx_d;

  logic                 misaligned;
  logic                 out_of_range;
  logic                 req_err;
  logic                 accept;
  logic [IDX-1:0]       word_idx;

  logic                 ram_we;
  logic                 ram_re;
  logic [IDX-1:0]       ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [BYTES-1:0]     ram_be;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                 rsp_valid_q;
  logic                 rsp_load_q;
  logic                 rsp_err_q;

  always_comb begin
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (i < OFF && reqAddr[i]) misaligned = 1'b1;
      if (i >= OFF + IDX && reqAddr[i]) out_of_range = 1'b1;
    end
  end

  assign word_idx = reqAddr[OFF+IDX-1:OFF];
  assign req_err  = misaligned | out_of_range;

  // Handshake: a request transfers on any rising edge where reqValid and reqReady
  // are both high; reqReady depends only on state, never on reqValid. The response
  // is a single rspValid pulse the following cycle and cannot be stalled.
  assign accept = reqValid & reqReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    reqReady  = 1'b0;
    clearBusy = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = word_idx;
    ram_wdata = reqWData;
    ram_be    = reqByteEn;
    case (state_q)
      CLEAR: begin
        clearBusy = 1'b1;
        // Held low in reset so the array is only touched once the sequence runs.
        ram_we    = rstN;
        ram_addr  = clr_idx_q;
        ram_wdata = '0;
        ram_be    = '1;
        clr_idx_d = clr_idx_q + IDX'(1);
        if (clr_idx_q == IDX'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        reqReady = rstN;
        ram_we   = reqValid & rstN & reqWrite & ~req_err;
        ram_re   = reqValid & rstN & ~reqWrite & ~req_err;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  memArrayBe #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .be   (ram_be),
    .rdata(ram_rdata)
  );

  // Load/error flags only move on an accept, so rspRData and rspError hold between pulses.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rsp_valid_q <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_load_q <= ~reqWrite & ~req_err;
        rsp_err_q  <= req_err;
      end
    end
  end

  assign rspValid = rsp_valid_q;
  assign rspError = rsp_err_q;
  assign rspRData = rsp_load_q ? ram_rdata : '0;
  assign dbgState = state_q;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Bench for data_memory_pipe: directed scenarios plus random traffic, checked by a
// scoreboard fed from a word-array reference model.
module tb_data_memory_pipe;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int BYTES = DW / 8;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqWrite = 1'b0;
  logic [AW-1:0] reqAddr = '0;
  logic [DW-1:0] reqWData = '0;
  logic [BYTES-1:0] reqByteEn = '0;
  logic          reqReady;
  logic          rspValid;
  logic [DW-1:0] rspRData;
  logic          rspError;
  logic          clearBusy;
  logic          dbgState;

  int n_checks = 0;
  int n_fail   = 0;
  int neg_cnt  = 0;

  logic [DW-1:0] model_mem [DEPTH];
  // Entry layout: {due negedge count[31:0], error, rdata[31:0]}
  logic [64:0] exp_q[$];

  data_memory_pipe #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqWrite (reqWrite),
    .reqAddr  (reqAddr),
    .reqWData (reqWData),
    .reqByteEn(reqByteEn),
    .rspValid (rspValid),
    .rspRData (rspRData),
    .rspError (rspError),
    .clearBusy(clearBusy),
    .dbgState (dbgState)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_access(input logic wr, input logic [AW-1:0] addr,
                                       input logic [DW-1:0] wdata, input logic [BYTES-1:0] be,
                                       output logic err, output logic [DW-1:0] data);
    int unsigned a;
    int unsigned w;
    a    = addr;
    err  = (a % BYTES != 0) || (a >= DEPTH * BYTES);
    data = '0;
    if (!err) begin
      w = a / BYTES;
      if (wr) begin
        for (int b = 0; b < BYTES; b++) begin
          if (be[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        data = model_mem[w];
      end
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [64:0] e;
    neg_cnt++;
    if (exp_q.size() > 0 && int'(exp_q[0][64:33]) == neg_cnt) begin
      e = exp_q.pop_front();
      check("rsp_valid", rspValid, 1);
      if (rspValid) begin
        check("rsp_error", rspError, e[32]);
        check("rsp_rdata", rspRData, e[31:0]);
      end
    end else if (rspValid) begin
      check("rsp_spurious_valid", rspValid, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [BYTES-1:0] be, input bit expect_rsp);
    int guard;
    logic err;
    logic [DW-1:0] data;
    @(posedge clk);
    #1;
    reqValid  = 1'b1;
    reqWrite  = wr;
    reqAddr   = addr;
    reqWData  = wdata;
    reqByteEn = be;
    guard = 0;
    while (!reqReady && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("req_ready", reqReady, 1);
    if (reqReady) begin
      model_access(wr, addr, wdata, be, err, data);
      // Accepted at the next posedge; pulse is seen at the negedge after that.
      if (expect_rsp) exp_q.push_back({32'(neg_cnt + 2), err, data});
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    int cnt;
    rstN     = 1'b0;
    reqValid = 1'b0;
    exp_q.delete();
    repeat (hold) begin
      @(negedge clk);
      #1;
      check("rst_rsp_valid", rspValid, 0);
      check("rst_rsp_rdata", rspRData, 0);
      check("rst_rsp_error", rspError, 0);
      check("rst_req_ready", reqReady, 0);
      check("rst_clear_busy", clearBusy, 1);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    cnt = 0;
    while (clearBusy && cnt < 100) begin
      check("ready_during_clear", reqReady, 0);
      cnt++;
      @(negedge clk);
      #1;
    end
    check("clear_cycles", cnt, DEPTH);
    check("ready_after_clear", reqReady, 1);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] addr;
    int k;

    do_reset(3);

    // Freshly cleared top word
    drive_req(1'b0, 32'h3C, '0, '0, 1'b1);

    // Byte-enable merge
    drive_req(1'b1, 32'h8, 32'hDEADBEEF, 4'b1111, 1'b1);
    drive_req(1'b1, 32'h8, 32'h000000AA, 4'b0001, 1'b1);
    drive_req(1'b0, 32'h8, '0, '0, 1'b1);

    // Back-to-back store then load to the same word
    drive_req(1'b1, 32'h4, 32'h12345678, 4'b1111, 1'b1);
    drive_req(1'b0, 32'h4, '0, '0, 1'b1);

    // Error cases leave the array untouched; zero byte-enable is a no-op
    drive_req(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, 1'b1);
    drive_req(1'b0, 32'h6, '0, '0, 1'b1);
    drive_req(1'b1, 32'h40, 32'hFFFFFFFF, 4'b1111, 1'b1);
    drive_req(1'b1, 32'h2, 32'h11111111, 4'b1111, 1'b1);
    drive_req(1'b0, 32'h0, '0, '0, 1'b1);
    drive_req(1'b1, 32'hC, 32'h55555555, 4'b0000, 1'b1);
    drive_req(1'b0, 32'hC, '0, '0, 1'b1);
    idle();
    repeat (3) @(posedge clk);

    // Reset in the middle of the clear sequence restarts it from index 0
    rstN     = 1'b0;
    reqValid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (7) begin
      @(negedge clk);
      #1;
      check("clear_busy_partial", clearBusy, 1);
    end
    do_reset(2);
    drive_req(1'b0, 32'h8, '0, '0, 1'b1);
    drive_req(1'b0, 32'h4, '0, '0, 1'b1);

    // Reset the cycle after a load is accepted: its response must never appear
    drive_req(1'b1, 32'h14, 32'hA5A5A5A5, 4'b1111, 1'b1);
    drive_req(1'b0, 32'h14, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    do_reset(3);
    drive_req(1'b0, 32'h14, '0, '0, 1'b1);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        k = $urandom_range(0, 9);
        if (k == 0)      addr = 32'($urandom_range(0, DEPTH - 1) * BYTES + $urandom_range(1, BYTES - 1));
        else if (k == 1) addr = 32'($urandom_range(DEPTH, 4096) * BYTES);
        else             addr = 32'($urandom_range(0, DEPTH - 1) * BYTES);
        drive_req(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      end
    end
    idle();
    repeat (5) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
